// File: rtl/ram_pkg.sv
// Shared definitions for the ram_* memory family:
// read-during-write encodings and the clear-engine state enum.
package ram_pkg;

    typedef enum logic {
        RD_FIRST = 1'b0,
        WR_FIRST = 1'b1
    } rd_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } init_state_e;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/ram_init_ctrl.sv
// Clear engine: walks every address once, one word per cycle,
// after reset or on an init_req pulse.
module ram_init_ctrl
    import ram_pkg::*;
#(
    parameter  int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  init_req,
    output logic                  init_busy,
    output logic                  init_we,
    output logic [ADDR_WIDTH-1:0] init_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    init_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_we = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (init_req) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            ST_INIT: begin
                // init_req is deliberately ignored while clearing
                init_we = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
        endcase
    end

    assign init_busy = (state_q == ST_INIT);
    assign init_addr = cnt_q;

endmodule

// File: rtl/ram_tp_bytemask_init.sv
// One-write/one-read RAM with byte enables, selectable collision
// behaviour, optional output register and a sequential clear engine.
module ram_tp_bytemask_init
    import ram_pkg::*;
#(
    parameter  int                    DATA_WIDTH = 32,
    parameter  int                    DEPTH      = 16,
    parameter  int                    RD_MODE    = 0,
    parameter  int                    OUT_REG    = 0,
    parameter  logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int                    ADDR_WIDTH = $clog2(DEPTH),
    localparam int                    BE_WIDTH   = DATA_WIDTH / BYTE_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cen,
    input  logic                  wen,
    input  logic [BE_WIDTH-1:0]   ben,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  init_req,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  init_busy
);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  init_we;
    logic [ADDR_WIDTH-1:0] init_addr;

    logic                  user_we, rd_acc, raddr_ok;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr, rd_idx;
    logic [DATA_WIDTH-1:0] mem_wdata, rd_word;
    logic [BE_WIDTH-1:0]   mem_be;

    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  rvalid1_q, rvalid1_d;

    ram_init_ctrl #(
        .DEPTH(DEPTH)
    ) u_init (
        .clock    (clock),
        .reset    (reset),
        .init_req (init_req),
        .init_busy(init_busy),
        .init_we  (init_we),
        .init_addr(init_addr)
    );

    assign user_we  = cen & wen & ~init_busy & in_range(waddr);
    assign rd_acc   = cen & ren & ~init_busy;
    assign raddr_ok = in_range(raddr);
    assign rd_idx   = raddr_ok ? raddr : '0;

    // The clear engine owns the write port whenever it runs
    always_comb begin
        mem_we    = init_we | user_we;
        mem_addr  = init_we ? init_addr : waddr;
        mem_wdata = init_we ? INIT_VALUE : wdata;
        mem_be    = init_we ? '1 : ben;
    end

    always_ff @(posedge clock) begin
        for (int k = 0; k < BE_WIDTH; k++) begin
            if (mem_we && mem_be[k]) begin
                mem[mem_addr][BYTE_W*k +: BYTE_W] <= mem_wdata[BYTE_W*k +: BYTE_W];
            end
        end
    end

    // The array read sees pre-write contents; write-first merges here
    always_comb begin
        rd_word = mem[rd_idx];
        if (RD_MODE == int'(WR_FIRST) && user_we && waddr == raddr) begin
            for (int k = 0; k < BE_WIDTH; k++) begin
                if (ben[k]) begin
                    rd_word[BYTE_W*k +: BYTE_W] = wdata[BYTE_W*k +: BYTE_W];
                end
            end
        end
        if (!raddr_ok) begin
            rd_word = '0;
        end
    end

    always_comb begin
        rdata1_d  = rd_acc ? rd_word : rdata1_q;
        rvalid1_d = rd_acc;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata1_q  <= '0;
            rvalid1_q <= 1'b0;
        end else begin
            rdata1_q  <= rdata1_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] rdata2_q, rdata2_d;
        logic                  rvalid2_q, rvalid2_d;

        always_comb begin
            rdata2_d  = rvalid1_q ? rdata1_q : rdata2_q;
            rvalid2_d = rvalid1_q;
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                rdata2_q  <= '0;
                rvalid2_q <= 1'b0;
            end else begin
                rdata2_q  <= rdata2_d;
                rvalid2_q <= rvalid2_d;
            end
        end

        assign rdata  = rdata2_q;
        assign rvalid = rvalid2_q;
    end else begin : g_nreg
        assign rdata  = rdata1_q;
        assign rvalid = rvalid1_q;
    end

endmodule

// File: doc/ram_tp_bytemask_init.md
# ram_tp_bytemask_init

Parametrised two-port (one write, one read) RAM with byte-granular write enables, selectable read-during-write behaviour, optional output pipeline register and a self-clearing initialisation engine. Replaces whole-array reset clearing with a sequential clear of one word per cycle, so the array maps to synthesizable memory. Used as the generic buffer and table memory under FIFOs, caches and register files.

## Interface
- DATA_WIDTH, 32, word width; multiple of 8, at least 8
- DEPTH, 16, number of words; at least 2; non-power-of-two allowed
- RD_MODE, 0, read-during-write to the same address: 0 = read-first (old data), 1 = write-first (merged new data)
- OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1)
- INIT_VALUE, 0, DATA_WIDTH-bit word written to every address by the clear engine
- Derived: ADDR_WIDTH = $clog2(DEPTH), BE_WIDTH = DATA_WIDTH/8
- clock  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-high
- cen  input  1  chip enable; when 0 no read or write is accepted
- wen  input  1  write request
- ben  input  BE_WIDTH  byte enables; bit k controls wdata[8k+7:8k]
- waddr  input  ADDR_WIDTH  write address
- wdata  input  DATA_WIDTH  write data
- ren  input  1  read request
- raddr  input  ADDR_WIDTH  read address
- init_req  input  1  one-cycle pulse that starts a full clear
- rdata  output  DATA_WIDTH  read data; holds its value between reads
- rvalid  output  1  one-cycle pulse when rdata carries a new read result
- init_busy  output  1  high while the clear engine is running

## Operation
- Write accepted when cen & wen & !init_busy & (waddr < DEPTH): ram[waddr] byte k <= wdata byte k where ben[k]=1; other bytes unchanged. ben = 0 means no change.
- Read accepted when cen & ren & !init_busy: result is ram[raddr]. If raddr >= DEPTH, the result is 0.
- Same-cycle read and write to the same address:
  - RD_MODE=0 returns the pre-write word.
  - RD_MODE=1 returns the byte-merged post-write word.
  - Reads and writes to different addresses are independent.
- Clear engine FSM, states IDLE and INIT:
  - Reset places the FSM in INIT with counter = 0, so a clear always follows reset.
  - In INIT, writes INIT_VALUE to ram[counter] each cycle, increments the counter, and returns to IDLE after address DEPTH-1.
  - In IDLE, init_req moves the FSM to INIT with counter = 0.
  - init_req during INIT is ignored.
- While init_busy = 1, user reads and writes are dropped (no rvalid, no array change). Reads already in the pipeline still complete.

## Timing
- Reset values: rdata = 0, rvalid = 0, init_busy = 1, FSM = INIT, counter = 0, pipeline valid bits = 0. Array contents are not reset directly.
- Clear duration: exactly DEPTH cycles of init_busy = 1, measured from the first rising edge after reset deassertion, or from the edge that samples init_req.
- Read latency:
  - OUT_REG=0: read accepted at edge N gives rdata/rvalid valid after edge N.
  - OUT_REG=1: valid after edge N+1.
- Fully pipelined: one read per cycle, back-to-back rvalid.
- cen = 0 does not stall the output stage; an in-flight read still completes.
- Reset asserted mid-clear or mid-read: all outputs go to reset values immediately and the clear restarts from address 0.
- Write becomes visible to a read on a later cycle: a read accepted at edge N+1 sees a write accepted at edge N.

## Structure
- Shared package ram_pkg: RD_MODE encodings (RD_FIRST=0, WR_FIRST=1) and the clear-FSM state enum. Shared with other ram_* blocks.
- Sub-module ram_init_ctrl: clear FSM plus address counter. Outputs init_busy, init_we, init_addr. Parameter DEPTH.
- Top level contains the array, the write-port mux between user and clear engine, the collision bypass, and the optional output stage.

## Test plan
- Reset, then wait: init_busy high exactly 16 cycles (DEPTH=16, INIT_VALUE=0xA5A5A5A5); afterwards a read of every address returns 0xA5A5A5A5.
- Write addr 3 data 0x11223344 ben 0xF, then addr 3 data 0xAABBCCDD ben 0x5: read returns 0x11BB33DD with latency 1 (OUT_REG=0) or 2 (OUT_REG=1).
- Same-cycle write addr 5 = 0xFFFFFFFF ben 0xF and read addr 5 (old 0x0): RD_MODE=0 returns 0x00000000; RD_MODE=1 returns 0xFFFFFFFF.
- init_req mid-traffic: reads and writes during the 16 busy cycles produce no rvalid and no array change; a second init_req during INIT does not extend busy.
- DEPTH=12: write to addr 13 leaves the array unchanged; read of addr 13 returns 0 with rvalid asserted.
- Reset asserted at clear cycle 7 and during an OUT_REG=1 read: rvalid=0 and rdata=0 immediately; after release a full 16-cycle clear follows.
